// File: rtl/serial_parity_deserializer_if.sv
// Serial-in / word-out bundle for serial_parity_deserializer.
// master: serial link side (drives frame bits, observes words).
// slave : the deserializer (consumes frame bits, presents words).
interface serial_parity_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             serial_valid;
    logic             serial_data;
    logic             parallel_valid;
    logic [WIDTH-1:0] parallel_data;
    logic             parity_err;
    logic             frame_abort;

    modport master (
        output serial_valid,
        output serial_data,
        input  parallel_valid,
        input  parallel_data,
        input  parity_err,
        input  frame_abort
    );

    modport slave (
        input  serial_valid,
        input  serial_data,
        output parallel_valid,
        output parallel_data,
        output parity_err,
        output frame_abort
    );
endinterface

// File: rtl/serial_parity_deserializer.sv
// Bit-serial frame receiver: WIDTH data bits (LSB first) then one parity bit.
// Presents the reassembled word with a one-cycle valid pulse and a parity error flag.
// Optional mid-frame idle timeout enabled by defining SERIAL_PARITY_DESER_TIMEOUT_EN.
module serial_parity_deserializer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_parity_deserializer_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Reject parameter values the frame logic cannot handle.
    if (WIDTH < 2 || TIMEOUT < 2) begin : g_bad_params
        $error("serial_parity_deserializer: WIDTH and TIMEOUT must both be >= 2");
    end

    typedef enum logic {
        S_DATA   = 1'b0,
        S_PARITY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic             par_q,   par_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic             err_q,   err_d;

`ifdef SERIAL_PARITY_DESER_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q,  idle_d;
    logic              abort_q, abort_d;
`endif

    // Next-state: accept a bit only when serial_valid, frame it into data/parity phases.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = err_q;
`ifdef SERIAL_PARITY_DESER_TIMEOUT_EN
        idle_d  = idle_q;
        abort_d = 1'b0;
`endif

        if (bus.serial_valid) begin
            if (state_q == S_DATA) begin
                // Shifting in from the top leaves the first bit at position 0 after WIDTH bits.
                word_d = {bus.serial_data, word_q[WIDTH-1:1]};
                par_d  = par_q ^ bus.serial_data;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_PARITY;
                end
            end else begin
                data_d  = word_q;
                err_d   = (par_q ^ bus.serial_data) != 1'(ODD_PARITY);
                valid_d = 1'b1;
                cnt_d   = '0;
                par_d   = 1'b0;
                state_d = S_DATA;
            end
        end

`ifdef SERIAL_PARITY_DESER_TIMEOUT_EN
        // An accepted bit always beats an expiring idle counter.
        if (bus.serial_valid) begin
            idle_d = '0;
        end else if (cnt_q != '0 || state_q == S_PARITY) begin
            if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                state_d = S_DATA;
                cnt_d   = '0;
                par_d   = 1'b0;
                idle_d  = '0;
                abort_d = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            word_q  <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef SERIAL_PARITY_DESER_TIMEOUT_EN
            idle_q  <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
`ifdef SERIAL_PARITY_DESER_TIMEOUT_EN
            idle_q  <= idle_d;
            abort_q <= abort_d;
`endif
        end
    end

    assign bus.parallel_valid = valid_q;
    assign bus.parallel_data  = data_q;
    assign bus.parity_err     = err_q;
`ifdef SERIAL_PARITY_DESER_TIMEOUT_EN
    assign bus.frame_abort    = abort_q;
`else
    assign bus.frame_abort    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_parity_deserializer.sv
// Bench for serial_parity_deserializer: an even-parity and an odd-parity instance
// fed identical bit streams, compared every cycle against a queue-based frame model.
module tb_serial_parity_deserializer;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_parity_deserializer_if #(.WIDTH(WIDTH)) bus_e ();
    serial_parity_deserializer_if #(.WIDTH(WIDTH)) bus_o ();

    serial_parity_deserializer #(.WIDTH(WIDTH), .ODD_PARITY(0), .TIMEOUT(TIMEOUT)) dut_e (
        .clk (clk),
        .rst (rst),
        .bus (bus_e.slave)
    );

    serial_parity_deserializer #(.WIDTH(WIDTH), .ODD_PARITY(1), .TIMEOUT(TIMEOUT)) dut_o (
        .clk (clk),
        .rst (rst),
        .bus (bus_o.slave)
    );

    // Reference model: pending frame bits in a queue, word built once WIDTH+1 bits arrive.
    bit               pend[$];
    int               idle;
    logic             exp_valid, exp_err_e, exp_err_o, exp_abort;
    logic [WIDTH-1:0] exp_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int aborts = 0;
    int pulses = 0;
    int last_pulse = 0;

    task automatic model_reset();
        pend.delete();
        idle      = 0;
        exp_valid = 1'b0;
        exp_err_e = 1'b0;
        exp_err_o = 1'b0;
        exp_abort = 1'b0;
        exp_data  = '0;
    endtask

    task automatic model_step(input logic v, input logic b);
        int ones;
        exp_valid = 1'b0;
        exp_abort = 1'b0;
        if (v) begin
            pend.push_back(b);
            idle = 0;
            if (pend.size() == WIDTH + 1) begin
                ones = 0;
                for (int i = 0; i <= WIDTH; i++) ones += int'(pend[i]);
                for (int i = 0; i < WIDTH; i++) exp_data[i] = pend[i];
                exp_err_e = (ones % 2) != 0;
                exp_err_o = (ones % 2) != 1;
                exp_valid = 1'b1;
                pend.delete();
            end
        end else begin
`ifdef SERIAL_PARITY_DESER_TIMEOUT_EN
            if (pend.size() != 0) begin
                idle++;
                if (idle == TIMEOUT) begin
                    pend.delete();
                    idle      = 0;
                    exp_abort = 1'b1;
                end
            end
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("e_valid", 32'(bus_e.parallel_valid), 32'(exp_valid));
        chk("e_data",  32'(bus_e.parallel_data),  32'(exp_data));
        chk("e_err",   32'(bus_e.parity_err),     32'(exp_err_e));
        chk("e_abort", 32'(bus_e.frame_abort),    32'(exp_abort));
        chk("o_valid", 32'(bus_o.parallel_valid), 32'(exp_valid));
        chk("o_data",  32'(bus_o.parallel_data),  32'(exp_data));
        chk("o_err",   32'(bus_o.parity_err),     32'(exp_err_o));
    endtask

    // One clock: drive at negedge, advance model at posedge, sample 1ns later.
    task automatic cycle(input logic v, input logic b);
        @(negedge clk);
        bus_e.serial_valid = v;
        bus_e.serial_data  = b;
        bus_o.serial_valid = v;
        bus_o.serial_data  = b;
        @(posedge clk);
        model_step(v, b);
        #1;
        cyc++;
        if (bus_e.frame_abort === 1'b1) aborts++;
        if (bus_e.parallel_valid === 1'b1) begin
            pulses++;
            last_pulse = cyc;
        end
        check_all();
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic p, input int gap);
        for (int i = 0; i < WIDTH; i++) begin
            cycle(1'b1, w[i]);
            repeat (gap) cycle(1'b0, 1'($urandom));
        end
        cycle(1'b1, p);
    endtask

    initial begin
        int p0;
        int n;
        bus_e.serial_valid = 1'b0;
        bus_e.serial_data  = 1'b0;
        bus_o.serial_valid = 1'b0;
        bus_o.serial_data  = 1'b0;
        rst = 1'b1;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // 0xA5 even parity ok, then bad parity (odd instance sees the reverse).
        send_frame(8'hA5, 1'b0, 0);
        chk("a5_p0_data", 32'(bus_e.parallel_data), 32'h0000_00A5);
        chk("a5_p0_err",  32'(bus_e.parity_err), 32'd0);
        chk("a5_p0_odd_err", 32'(bus_o.parity_err), 32'd1);
        send_frame(8'hA5, 1'b1, 0);
        chk("a5_p1_err",  32'(bus_e.parity_err), 32'd1);
        chk("a5_p1_odd_err", 32'(bus_o.parity_err), 32'd0);
        cycle(1'b0, 1'b0);
        chk("a5_hold_data", 32'(bus_e.parallel_data), 32'h0000_00A5);

        // Gapped frame: exactly one pulse, only after the parity bit.
        n = pulses;
        send_frame(8'h5A, 1'b0, 3);
        chk("gap_pulses", 32'(pulses - n), 32'd1);
        chk("gap_data", 32'(bus_e.parallel_data), 32'h0000_005A);

        // Back-to-back frames with serial_valid held high.
        send_frame(8'h00, 1'b0, 0);
        p0 = last_pulse;
        chk("b2b_first", 32'(bus_e.parallel_data), 32'h0000_0000);
        send_frame(8'hFF, 1'b0, 0);
        chk("b2b_spacing", 32'(last_pulse - p0), 32'd9);
        chk("b2b_second", 32'(bus_e.parallel_data), 32'h0000_00FF);
        chk("b2b_err", 32'(bus_e.parity_err), 32'd0);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom));
        @(negedge clk);
        bus_e.serial_valid = 1'b0;
        bus_o.serial_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;
        n = pulses;
        send_frame(8'h3C, 1'b0, 0);
        chk("rst_pulses", 32'(pulses - n), 32'd1);
        chk("rst_data", 32'(bus_e.parallel_data), 32'h0000_003C);
        chk("rst_err", 32'(bus_e.parity_err), 32'd0);

        // Idle timeout mid-frame.
        n = aborts;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom));
        repeat (TIMEOUT) cycle(1'b0, 1'b0);
`ifdef SERIAL_PARITY_DESER_TIMEOUT_EN
        chk("to_abort", 32'(aborts - n), 32'd1);
        send_frame(8'h01, 1'b1, 0);
        chk("to_data", 32'(bus_e.parallel_data), 32'h0000_0001);
        chk("to_err", 32'(bus_e.parity_err), 32'd0);
`else
        chk("to_no_abort", 32'(aborts - n), 32'd0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        chk("to_stale_valid", 32'(bus_e.parallel_valid), 32'd1);
`endif

        // Randomized stream with occasional long idle stretches.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                repeat ($urandom_range(TIMEOUT - 2, TIMEOUT + 2)) cycle(1'b0, 1'($urandom));
            end
            cycle(($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end
endmodule
